turf_reset_sequencer: RTL and testbench

- Sequences clock-manager reset, lock wait, settle and event-path clear for the TURF trigger/readout datapath.
- Takes the raw one-shot clear, DCM-reset and disable controls decoded from the TURFIO register bus.
- Emits ordered, properly spaced reset/clear pulses and a trigger-inhibit level.
- Returns status for readback through the register-bus status word.

---
 rtl/turf_reset_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_turf_reset_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_reset_sequencer.sv
// turf_reset_sequencer: orders DCM reset, lock wait, settle and
// event-path clear pulses for the TURF trigger/readout datapath.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   clr_all_i      one-cycle full clear request (no DCM reset)
//   clr_evt_i      one-cycle event-path clear request
//   dcm_reset_i    level; rising edge requests full sequence with DCM reset
//   disable_i      level; forces trigger inhibit
//   dcm_locked_i   DCM lock, synchronous to clk_i
//   dcm_rst_o      DCM reset
//   clr_all_o      one-cycle full clear pulse
//   clr_evt_o      one-cycle event clear pulse
//   trig_inhibit_o blocks trigger generation
//   busy_o         sequencer not idle
//   lock_err_o     sticky lock-timeout flag
//   status_o       {lock_err, pending, busy, wd, 1'b0, state[2:0]}
//
// Build option: define TURF_SEQ_WATCHDOG_EN to compile in an idle
// lock-loss watchdog that self-launches a DCM reset sequence and
// reports it on status_o[4].
module turf_reset_sequencer #(
    parameter int unsigned DCM_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned SETTLE_CYCLES  = 256,
    parameter int unsigned INHIBIT_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_all_i,
    input  logic       clr_evt_i,
    input  logic       dcm_reset_i,
    input  logic       disable_i,
    input  logic       dcm_locked_i,
    output logic       dcm_rst_o,
    output logic       clr_all_o,
    output logic       clr_evt_o,
    output logic       trig_inhibit_o,
    output logic       busy_o,
    output logic       lock_err_o,
    output logic [7:0] status_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DCM_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_CLEAR     = 3'd4,
        S_INHIBIT   = 3'd5,
        S_EVT_CLR   = 3'd6
    } state_t;

    // Last counter value of each timed state; the counter starts at
    // zero on entry, so a state lasting N cycles exits at N-1.
    localparam logic [15:0] DCM_LAST =
        16'(DCM_RST_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST =
        16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST =
        16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] INH_LAST =
        16'(INHIBIT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic        dcm_prev_q;
    logic        pend_q;
    logic        pend_d;
    logic        pend_dcm_q;
    logic        pend_dcm_d;
    logic        lock_err_q;
    logic        lock_err_d;
    logic        dcm_rise;
    logic        full_req;
    logic        with_dcm;
    logic        launch;
    logic        wd_fire;
    logic        wd_flag;

    assign dcm_rise = dcm_reset_i & ~dcm_prev_q;
    assign full_req = clr_all_i | dcm_rise;

`ifdef TURF_SEQ_WATCHDOG_EN
    logic [3:0] wd_cnt_q;
    logic       wd_flag_q;

    // wd_cnt_q holds the number of earlier consecutive low-lock idle
    // cycles, so a value of 15 marks the 16th.
    assign wd_fire = (state_q == S_IDLE)
                   & ~dcm_locked_i
                   & (wd_cnt_q == 4'd15);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            wd_flag_q <= 1'b0;
        end else begin
            if ((state_q != S_IDLE) || dcm_locked_i) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != 4'd15) begin
                wd_cnt_q <= wd_cnt_q + 4'd1;
            end
            if (wd_fire) begin
                wd_flag_q <= 1'b1;
            end
        end
    end

    assign wd_flag = wd_flag_q;
`else
    assign wd_fire = 1'b0;
    assign wd_flag = 1'b0;
`endif

    // A deferred request launches exactly like a fresh one.
    assign launch   = full_req | pend_q | wd_fire;
    assign with_dcm = dcm_rise | pend_dcm_q | wd_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_dcm_d = pend_dcm_q;
        lock_err_d = lock_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d    = with_dcm ? S_DCM_RST
                                          : S_SETTLE;
                    pend_d     = 1'b0;
                    pend_dcm_d = 1'b0;
                end else if (clr_evt_i) begin
                    state_d = S_INHIBIT;
                end
            end
            S_DCM_RST: begin
                if (cnt_q == DCM_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (dcm_locked_i) begin
                    state_d    = S_SETTLE;
                    lock_err_d = 1'b0;
                end else if (cnt_q == LOCK_LAST) begin
                    // Timeout still runs the clear.
                    state_d    = S_CLEAR;
                    lock_err_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = S_EVT_CLR;
                end
            end
            S_EVT_CLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Busy: hold one full request; event-only requests are
        // dropped since every sequence clears the event path.
        if ((state_q != S_IDLE) && full_req) begin
            pend_d     = 1'b1;
            pend_dcm_d = pend_dcm_q | dcm_rise;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            dcm_prev_q     <= 1'b0;
            pend_q         <= 1'b0;
            pend_dcm_q     <= 1'b0;
            lock_err_q     <= 1'b0;
            dcm_rst_o      <= 1'b0;
            clr_all_o      <= 1'b0;
            clr_evt_o      <= 1'b0;
            trig_inhibit_o <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            dcm_prev_q     <= dcm_reset_i;
            pend_q         <= pend_d;
            pend_dcm_q     <= pend_dcm_d;
            lock_err_q     <= lock_err_d;
            dcm_rst_o      <= (state_q == S_DCM_RST);
            clr_all_o      <= (state_q == S_CLEAR);
            clr_evt_o      <= (state_q == S_CLEAR)
                            | (state_q == S_EVT_CLR);
            trig_inhibit_o <= disable_i
                            | (state_q != S_IDLE);
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign lock_err_o = lock_err_q;
    assign status_o   = {lock_err_q, pend_q, busy_o,
                         wd_flag, 1'b0, state_q};

endmodule

// File: tb/tb_turf_reset_sequencer.sv
// tb_turf_reset_sequencer: directed stimulus for turf_reset_sequencer
// checked against a segment-plan model and literal expectations.
module tb_turf_reset_sequencer;

    localparam int D = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int I = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_all = 1'b0;
    logic       clr_evt = 1'b0;
    logic       dcm_reset = 1'b0;
    logic       dis = 1'b0;
    logic       locked = 1'b1;
    logic       dcm_rst_o;
    logic       clr_all_o;
    logic       clr_evt_o;
    logic       trig_inhibit_o;
    logic       busy_o;
    logic       lock_err_o;
    logic [7:0] status_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    turf_reset_sequencer #(
        .DCM_RST_CYCLES(D),
        .LOCK_TIMEOUT  (T),
        .SETTLE_CYCLES (S),
        .INHIBIT_CYCLES(I)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clr_all_i     (clr_all),
        .clr_evt_i     (clr_evt),
        .dcm_reset_i   (dcm_reset),
        .disable_i     (dis),
        .dcm_locked_i  (locked),
        .dcm_rst_o     (dcm_rst_o),
        .clr_all_o     (clr_all_o),
        .clr_evt_o     (clr_evt_o),
        .trig_inhibit_o(trig_inhibit_o),
        .busy_o        (busy_o),
        .lock_err_o    (lock_err_o),
        .status_o      (status_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Model: a running sequence is a plan of (phase code, length)
    // segments; an empty plan means idle. A wait-for-lock segment is
    // replaced by settle+clear when lock shows up.
    int codes[$];
    int lens[$];
    int age = 0;
    bit m_pend = 0, m_pdcm = 0, m_err = 0, m_prev = 0;
    bit m_wdflag = 0;
    int m_wd = 0;
    bit e_dcm = 0, e_all = 0, e_evt = 0, e_inh = 0;

    function automatic int cur_code();
        return (codes.size() != 0) ? codes[0] : 0;
    endfunction

    task automatic plan_full(bit dcm);
        codes.delete();
        lens.delete();
        if (dcm) begin
            codes.push_back(1); lens.push_back(D);
            codes.push_back(2); lens.push_back(T);
        end else begin
            codes.push_back(3); lens.push_back(S);
        end
        codes.push_back(4); lens.push_back(1);
        age = 0;
    endtask

    always @(posedge clk) begin
        int pre;
        bit rise, full, wdfire;
        pre = cur_code();
        if (rst) begin
            codes.delete();
            lens.delete();
            age = 0; m_pend = 0; m_pdcm = 0; m_err = 0;
            m_prev = 0; m_wd = 0; m_wdflag = 0;
            e_dcm = 0; e_all = 0; e_evt = 0; e_inh = 0;
        end else begin
            e_dcm = (pre == 1);
            e_all = (pre == 4);
            e_evt = (pre == 4) || (pre == 6);
            e_inh = dis || (pre != 0);
            rise = dcm_reset && !m_prev;
            m_prev = dcm_reset;
            full = clr_all || rise;
            wdfire = 0;
`ifdef TURF_SEQ_WATCHDOG_EN
            wdfire = (pre == 0) && !locked && (m_wd == 15);
            if (pre != 0 || locked) m_wd = 0;
            else if (m_wd < 15) m_wd++;
            if (wdfire) m_wdflag = 1;
`endif
            if (pre == 0) begin
                if (full || m_pend || wdfire) begin
                    plan_full(rise || m_pdcm || wdfire);
                    m_pend = 0;
                    m_pdcm = 0;
                end else if (clr_evt) begin
                    codes.push_back(5); lens.push_back(I);
                    codes.push_back(6); lens.push_back(1);
                    age = 0;
                end
            end else begin
                if (full) begin
                    m_pend = 1;
                    m_pdcm = m_pdcm || rise;
                end
                if (pre == 2 && locked) begin
                    plan_full(0);
                    m_err = 0;
                end else begin
                    age++;
                    if (age == lens[0]) begin
                        if (pre == 2) m_err = 1;
                        void'(codes.pop_front());
                        void'(lens.pop_front());
                        age = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] es;
        es = {m_err, m_pend, codes.size() != 0, m_wdflag,
              1'b0, 3'(cur_code())};
        chk("dcm_rst_o", int'(dcm_rst_o), int'(e_dcm));
        chk("clr_all_o", int'(clr_all_o), int'(e_all));
        chk("clr_evt_o", int'(clr_evt_o), int'(e_evt));
        chk("trig_inhibit_o", int'(trig_inhibit_o), int'(e_inh));
        chk("lock_err_o", int'(lock_err_o), int'(m_err));
        chk("busy_o", int'(busy_o), int'(codes.size() != 0));
        chk("status_o", int'(status_o), int'(es));
    end

    int n_dcm, n_all, n_evt, n_evt_alone, n_inh_pre;
    int n_wait, n_busy, n_any, first_all, last_all, first_evt;
    bit saw_pend;

    task automatic clear_counts();
        n_dcm = 0; n_all = 0; n_evt = 0; n_evt_alone = 0;
        n_inh_pre = 0; n_wait = 0; n_busy = 0; n_any = 0;
        first_all = -1; last_all = -1; first_evt = -1;
        saw_pend = 0;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(negedge clk);
            if (dcm_rst_o) n_dcm++;
            if (clr_all_o) begin
                n_all++;
                if (first_all < 0) first_all = cyc;
                last_all = cyc;
            end
            if (clr_evt_o) begin
                n_evt++;
                if (first_evt < 0) first_evt = cyc;
                if (!clr_all_o) n_evt_alone++;
            end
            if (trig_inhibit_o && n_evt == 0) n_inh_pre++;
            if (status_o[2:0] == 3'd2) n_wait++;
            if (status_o[6]) saw_pend = 1;
            if (busy_o) n_busy++;
            if (dcm_rst_o | clr_all_o | clr_evt_o |
                trig_inhibit_o | busy_o | lock_err_o) n_any++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        int k;
        clear_counts();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        clear_counts();
        run(10);
        chk("t1_status", int'(status_o), 0);
        chk("t1_any_out", n_any, 0);

        // 2: DCM reset, lock 3 cycles after dcm_rst_o falls
        clear_counts();
        dcm_reset = 1'b1;
        locked = 1'b0;
        run(1);
        dcm_reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_dcm > 0 && !dcm_rst_o) break;
            run(1);
        end
        run(2);
        locked = 1'b1;
        k = cyc;
        for (int i = 0; i < 50 && n_all == 0; i++) run(1);
        run(3);
        chk("t2_dcm_cycles", n_dcm, 4);
        chk("t2_clr_pulses", n_all, 1);
        chk("t2_lock_to_clr", first_all - k, 10);
        chk("t2_lock_err", int'(lock_err_o), 0);

        // 3: lock timeout
        clear_counts();
        dcm_reset = 1'b1;
        locked = 1'b0;
        run(1);
        dcm_reset = 1'b0;
        for (int i = 0; i < 100 && n_all == 0; i++) run(1);
        locked = 1'b1;
        run(2);
        chk("t3_wait_cycles", n_wait, 20);
        chk("t3_clr_pulses", n_all, 1);
        chk("t3_lock_err", int'(lock_err_o), 1);
        run(5);
        chk("t3_err_sticky", int'(status_o[7]), 1);

        // 4: disable, then event-only clear
        dis = 1'b1;
        run(3);
        dis = 1'b0;
        run(2);
        clear_counts();
        clr_evt = 1'b1;
        k = cyc;
        run(1);
        clr_evt = 1'b0;
        for (int i = 0; i < 50 && n_evt == 0; i++) run(1);
        run(2);
        chk("t4_evt_pulses", n_evt, 1);
        chk("t4_clr_all", n_all, 0);
        chk("t4_inh_lead", int'(n_inh_pre >= 8), 1);
        chk("t4_evt_latency", first_evt - k, 10);

        // 5: clr_all + clr_evt together, then clr_all mid-settle
        clear_counts();
        clr_all = 1'b1;
        clr_evt = 1'b1;
        k = cyc;
        run(1);
        clr_all = 1'b0;
        clr_evt = 1'b0;
        run(3);
        clr_all = 1'b1;
        run(1);
        clr_all = 1'b0;
        for (int i = 0; i < 100 && n_all < 2; i++) run(1);
        run(2);
        chk("t5_clr_pulses", n_all, 2);
        chk("t5_evt_alone", n_evt_alone, 0);
        chk("t5_pending_seen", int'(saw_pend), 1);
        chk("t5_first_clr", first_all - k, 10);
        chk("t5_second_clr", last_all - k, 20);

        // 6: reset mid-DCM_RST with a pending request
        clear_counts();
        dcm_reset = 1'b1;
        run(1);
        dcm_reset = 1'b0;
        run(2);
        clr_all = 1'b1;
        run(1);
        clr_all = 1'b0;
        chk("t6_pending", int'(status_o[6]), 1);
        chk("t6_dcm_rst_on", int'(dcm_rst_o), 1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("t6_dcm_rst_off", int'(dcm_rst_o), 0);
        chk("t6_status", int'(status_o), 0);
        run(5);
        chk("t6_idle_after", int'(status_o), 0);

        // lock loss while idle
        clear_counts();
        locked = 1'b0;
        run(20);
        locked = 1'b1;
`ifdef TURF_SEQ_WATCHDOG_EN
        chk("t6_wd_flag", int'(status_o[4]), 1);
        chk("t6_wd_busy", int'(n_busy > 0), 1);
`else
        chk("t6_wd_flag", int'(status_o[4]), 0);
        chk("t6_wd_busy", n_busy, 0);
`endif
        for (int i = 0; i < 200 && busy_o; i++) run(1);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
